// File: rtl/ddr_cmd_queue.sv
// rtl/ddr_cmd_queue.sv - request queue and one-at-a-time sequencer in front of ddr_controller
// Optional DDR_CMD_QUEUE_STATS_EN adds stat_o with saturating write/read/error counters.
module ddr_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  up_cmd,
  input  logic        up_cmd_vld,
  input  logic [23:0] up_addr,
  input  logic [31:0] up_data_in,
  output logic        up_full,
  output logic        up_overflow,
  output logic        up_rsp_vld,
  output logic [31:0] up_rsp_data,
  output logic        up_rsp_err,
  output logic [3:0]  user_cmd,
  output logic        user_cmd_vld,
  output logic [23:0] user_addr,
  output logic [31:0] user_data_in,
  input  logic [31:0] user_data_out,
  input  logic        user_data_out_vld,
  output logic        ddr_user_confirm,
  input  logic        ddr_busy,
  input  logic        ddr_ack,
  input  logic        ddr_ready
`ifdef DDR_CMD_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_o
`endif
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]       CMD_RD   = 4'd0;
  localparam logic [3:0]       CMD_WR   = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CONFIRM,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [59:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             push, pop, empty;
  logic [3:0]       head_cmd;
  logic [23:0]      head_addr;
  logic [31:0]      head_data;
  logic             head_legal;

  logic [3:0]       hold_cmd;
  logic [23:0]      hold_addr;
  logic [31:0]      hold_data;
  logic             hold_err;
  logic             hold_is_wr;
  logic [31:0]      rsp_data_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic             issue_go, wait_done, wait_tmo;

  assign {head_cmd, head_addr, head_data} = mem[rd_ptr];
  assign head_legal = (head_cmd == CMD_RD) || (head_cmd == CMD_WR);
  assign hold_is_wr = (hold_cmd == CMD_WR);
  assign empty      = (count == '0);
  assign push       = up_cmd_vld && !up_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {up_cmd, up_addr, up_data_in};
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      up_full     <= 1'b0;
      up_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      up_full <= (count_nxt == FULL_CNT);
      if (up_cmd_vld && up_full) up_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pop) state_nxt = head_legal ? S_ISSUE : S_RESP;
      S_ISSUE:   if (issue_go) state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_done)     state_nxt = S_CONFIRM;
        else if (wait_tmo) state_nxt = S_RESP;
      end
      S_CONFIRM: state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Nothing leaves the queue until the controller has initialised, so a
  // not-ready controller lets the full DEPTH entries back up.
  always_comb begin
    pop       = 1'b0;
    issue_go  = 1'b0;
    wait_done = 1'b0;
    wait_tmo  = 1'b0;
    case (state)
      S_IDLE:  pop      = !empty && ddr_ready;
      S_ISSUE: issue_go = ddr_ready && !ddr_busy;
      S_WAIT: begin
        wait_done = hold_is_wr ? ddr_ack : user_data_out_vld;
        wait_tmo  = !wait_done && (tmo_cnt == TMO_LAST);
      end
      default: ;
    endcase
  end

  // Strobes are registered on the edge that leaves their state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cmd         <= '0;
      hold_addr        <= '0;
      hold_data        <= '0;
      hold_err         <= 1'b0;
      rsp_data_q       <= '0;
      tmo_cnt          <= '0;
      user_cmd         <= '0;
      user_addr        <= '0;
      user_data_in     <= '0;
      user_cmd_vld     <= 1'b0;
      ddr_user_confirm <= 1'b0;
      up_rsp_vld       <= 1'b0;
      up_rsp_data      <= '0;
      up_rsp_err       <= 1'b0;
    end else begin
      user_cmd_vld     <= issue_go;
      ddr_user_confirm <= (state == S_CONFIRM);
      up_rsp_vld       <= (state == S_RESP);
      up_rsp_data      <= (state == S_RESP) ? rsp_data_q : '0;
      up_rsp_err       <= (state == S_RESP) && hold_err;
      if (pop) begin
        hold_cmd   <= head_cmd;
        hold_addr  <= head_addr;
        hold_data  <= head_data;
        hold_err   <= !head_legal;
        rsp_data_q <= '0;
      end
      if (issue_go) begin
        user_cmd     <= hold_cmd;
        user_addr    <= hold_addr;
        user_data_in <= hold_data;
        tmo_cnt      <= '0;
      end
      if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (wait_done && !hold_is_wr) rsp_data_q <= user_data_out;
        if (wait_tmo) hold_err <= 1'b1;
      end
    end
  end

`ifdef DDR_CMD_QUEUE_STATS_EN
  logic [11:0] stat_wr, stat_rd;
  logic [7:0]  stat_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_wr  <= '0;
      stat_rd  <= '0;
      stat_err <= '0;
    end else if (state == S_RESP) begin
      if (hold_err) begin
        if (stat_err != '1) stat_err <= stat_err + 1'b1;
      end else if (hold_is_wr) begin
        if (stat_wr != '1) stat_wr <= stat_wr + 1'b1;
      end else begin
        if (stat_rd != '1) stat_rd <= stat_rd + 1'b1;
      end
    end
  end

  assign stat_o = {stat_err, stat_rd, stat_wr};
`endif

endmodule

// File: tb/tb_ddr_cmd_queue.sv
// tb/tb_ddr_cmd_queue.sv - self-checking bench for ddr_cmd_queue
module tb_ddr_cmd_queue;
  localparam int TIMEOUT = 1024;
  localparam int NV      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  up_cmd;
  logic        up_cmd_vld;
  logic [23:0] up_addr;
  logic [31:0] up_data_in;
  logic        up_full, up_overflow, up_rsp_vld, up_rsp_err;
  logic [31:0] up_rsp_data;
  logic [3:0]  user_cmd;
  logic        user_cmd_vld;
  logic [23:0] user_addr;
  logic [31:0] user_data_in;
  logic [31:0] user_data_out;
  logic        user_data_out_vld;
  logic        ddr_user_confirm, ddr_busy, ddr_ack, ddr_ready;
`ifdef DDR_CMD_QUEUE_STATS_EN
  logic [31:0] stat_o;
`endif

  ddr_cmd_queue #(.DEPTH(4), .PTR_W(2), .TIMEOUT(TIMEOUT)) dut (
`ifdef DDR_CMD_QUEUE_STATS_EN
    .stat_o(stat_o),
`endif
    .clk(clk), .rst(rst),
    .up_cmd(up_cmd), .up_cmd_vld(up_cmd_vld), .up_addr(up_addr), .up_data_in(up_data_in),
    .up_full(up_full), .up_overflow(up_overflow),
    .up_rsp_vld(up_rsp_vld), .up_rsp_data(up_rsp_data), .up_rsp_err(up_rsp_err),
    .user_cmd(user_cmd), .user_cmd_vld(user_cmd_vld), .user_addr(user_addr),
    .user_data_in(user_data_in), .user_data_out(user_data_out),
    .user_data_out_vld(user_data_out_vld), .ddr_user_confirm(ddr_user_confirm),
    .ddr_busy(ddr_busy), .ddr_ack(ddr_ack), .ddr_ready(ddr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
  } rsp_t;

  vec_t vecs [NV];
  vec_t fill [5];
  rsp_t exp_q [$];
  vec_t iss_q [$];
  vec_t ctl_v;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, push_cyc = 0, issue_cyc = 0, rsp_cyc = 0;
  int n_issue = 0, n_confirm = 0, n_rsp = 0;
  int ctl_cnt = 0, ctrl_lat = 3;
  bit ctrl_silent = 1'b0;
  int c_iss, c_conf, c_rsp;
  bit legal;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: controller model plus response/issue scoreboard, sampled 1 ns after the edge.
  task automatic tick();
    rsp_t e;
    @(posedge clk);
    #1;
    cyc++;
    ddr_ack = 1'b0;
    user_data_out_vld = 1'b0;
    if (ddr_user_confirm) n_confirm++;
    if (user_cmd_vld) begin
      n_issue++;
      issue_cyc = cyc;
      if (iss_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        ctl_v = iss_q.pop_front();
        check("issue_cmd", user_cmd, ctl_v.cmd);
        check("issue_addr", user_addr, ctl_v.addr);
        check("issue_data", user_data_in, ctl_v.wdata);
        if (!ctrl_silent) ctl_cnt = ctrl_lat;
      end
    end
    if (ctl_cnt > 0) begin
      if (ctl_cnt == 1) begin
        if (ctl_v.cmd == 4'd1) ddr_ack = 1'b1;
        else begin
          user_data_out     = ctl_v.rdata;
          user_data_out_vld = 1'b1;
        end
      end
      ctl_cnt--;
    end
    if (up_rsp_vld) begin
      n_rsp++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", up_rsp_data, e.data);
        check("rsp_err", up_rsp_err, e.err);
      end
    end
  endtask

  task automatic push(input vec_t v, input bit accept);
    rsp_t r;
    up_cmd     = v.cmd;
    up_addr    = v.addr;
    up_data_in = v.wdata;
    up_cmd_vld = 1'b1;
    if (accept) begin
      r.data = v.exp_data;
      r.err  = v.exp_err;
      exp_q.push_back(r);
      if (v.cmd <= 4'd1) iss_q.push_back(v);
    end
    tick();
    push_cyc   = cyc;
    up_cmd_vld = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    up_cmd = '0; up_cmd_vld = 1'b0; up_addr = '0; up_data_in = '0;
    ddr_busy = 1'b0; ddr_ready = 1'b1; ddr_ack = 1'b0;
    user_data_out = '0; user_data_out_vld = 1'b0;

    vecs[0] = '{4'h1, 24'h000010, 32'h00001EAF, 32'h0,        1'b0, 32'h0};
    vecs[1] = '{4'h0, 24'h000020, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{4'h1, 24'hFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h0};
    vecs[3] = '{4'h0, 24'h000000, 32'h0,        32'h0,        1'b0, 32'h0};
    vecs[4] = '{4'h7, 24'h000055, 32'h12345678, 32'h0,        1'b1, 32'h0};
    vecs[5] = '{4'h0, 24'h123456, 32'h0,        32'hA5A55A5A, 1'b0, 32'hA5A55A5A};
    vecs[6] = '{4'hF, 24'h0000AA, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[7] = '{4'h2, 24'h000077, 32'h0,        32'h0,        1'b1, 32'h0};
    fill[0] = '{4'h1, 24'h000100, 32'h11111111, 32'h0,        1'b0, 32'h0};
    fill[1] = '{4'h0, 24'h000104, 32'h0,        32'h22222222, 1'b0, 32'h22222222};
    fill[2] = '{4'h1, 24'h000108, 32'h33333333, 32'h0,        1'b0, 32'h0};
    fill[3] = '{4'h0, 24'h00010C, 32'h0,        32'h44444444, 1'b0, 32'h44444444};
    fill[4] = '{4'h1, 24'h000110, 32'h55555555, 32'h0,        1'b0, 32'h0};

    repeat (3) tick();
    check("rst_flags", {up_full, up_overflow, up_rsp_vld, up_rsp_err, user_cmd_vld, ddr_user_confirm}, 0);
    check("rst_rsp_data", up_rsp_data, 0);
    check("rst_user_bus", {user_cmd, user_addr, user_data_in}, 0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      c_iss  = n_issue;
      c_conf = n_confirm;
      legal  = (vecs[i].cmd <= 4'd1);
      push(vecs[i], 1'b1);
      drain(60);
      check("issue_count", n_issue - c_iss, legal);
      check("confirm_count", n_confirm - c_conf, legal);
      if (legal) begin
        check("issue_latency", issue_cyc - push_cyc, 2);
        check("rsp_latency", rsp_cyc - issue_cyc, ctrl_lat + 2);
      end else begin
        check("err_latency", rsp_cyc - push_cyc, 2);
      end
      tick();
    end

    // Queue backs up while the controller is not ready.
    ddr_ready = 1'b0;
    c_iss = n_issue;
    for (int k = 0; k < 5; k++) begin
      push(fill[k], k < 4);
      if (k == 2) check("full_after_3", up_full, 0);
      if (k == 3) begin
        check("full_after_4", up_full, 1);
        check("ovf_after_4", up_overflow, 0);
      end
      if (k == 4) check("ovf_after_5", up_overflow, 1);
    end
    repeat (4) tick();
    check("full_held_not_ready", up_full, 1);
    check("no_issue_not_ready", n_issue - c_iss, 0);
    ddr_ready = 1'b1;
    drain(200);
    check("fill_issue_count", n_issue - c_iss, 4);
    check("full_after_drain", up_full, 0);
    check("ovf_sticky", up_overflow, 1);
    tick();

    // Read that the controller never answers.
    ctrl_silent = 1'b1;
    c_conf = n_confirm;
    push('{4'h0, 24'h000040, 32'h0, 32'h0, 1'b1, 32'h0}, 1'b1);
    drain(TIMEOUT + 50);
    check("tmo_latency", rsp_cyc - issue_cyc, TIMEOUT + 1);
    check("tmo_no_confirm", n_confirm - c_conf, 0);
    tick();

    // Asynchronous reset while a read waits and a write is queued.
    c_iss = n_issue;
    push('{4'h0, 24'hABCDEF, 32'h0, 32'h0, 1'b0, 32'h0}, 1'b1);
    push('{4'h1, 24'h000123, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0}, 1'b1);
    for (int n = 0; n < 20 && n_issue == c_iss; n++) tick();
    check("rst_test_issue_seen", n_issue - c_iss, 1);
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    check("async_rst_flags", {up_full, up_overflow, up_rsp_vld, up_rsp_err, user_cmd_vld, ddr_user_confirm}, 0);
    check("async_rst_user_bus", {user_cmd, user_addr, user_data_in}, 0);
    exp_q.delete();
    iss_q.delete();
    ctrl_silent = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    c_iss = n_issue;
    c_rsp = n_rsp;
    repeat (30) tick();
    check("post_rst_no_issue", n_issue - c_iss, 0);
    check("post_rst_no_rsp", n_rsp - c_rsp, 0);

    push(vecs[1], 1'b1);
    drain(60);
    check("recover_issue", n_issue - c_iss, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_queue.md
Name: ddr_cmd_queue

Overview:
- Command buffer and sequencer between the wishbone SDRAM slave (upstream) and ddr_controller (downstream).
- Queues read/write requests and issues them to the controller one at a time.
- Runs the ack / data-valid / confirm handshake and returns one response per request, with timeout protection.
- Frees the wishbone slave from tracking controller timing.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).
- TIMEOUT, 1024: cycles allowed in WAIT before an error response.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- up_cmd  input  4  request command; 0 = read, 1 = write, other values illegal.
- up_cmd_vld  input  1  one-cycle push strobe.
- up_addr  input  24  request address.
- up_data_in  input  32  write data.
- up_full  output  1  queue full; pushes are refused while high.
- up_overflow  output  1  sticky: a push was attempted while full.
- up_rsp_vld  output  1  one-cycle response strobe.
- up_rsp_data  output  32  read data, or 0 for a write.
- up_rsp_err  output  1  response is an error (timeout or illegal command); qualified by up_rsp_vld.
- user_cmd  output  4  to controller.
- user_cmd_vld  output  1  to controller; one-cycle strobe.
- user_addr  output  24  to controller.
- user_data_in  output  32  to controller.
- user_data_out  input  32  read data from controller.
- user_data_out_vld  input  1  read data valid.
- ddr_user_confirm  output  1  one-cycle confirm to controller.
- ddr_busy  input  1  controller busy.
- ddr_ack  input  1  write accepted by controller.
- ddr_ready  input  1  controller initialised.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Queue emptied; FSM goes to IDLE; timeout counter cleared.
  - All outputs 0 (up_full, up_overflow, up_rsp_*, user_*, ddr_user_confirm).
  - An in-flight request is dropped with no response.
- Queue:
  - Each entry holds {cmd[3:0], addr[23:0], data[31:0]}.
  - Push on the edge where up_cmd_vld = 1 and up_full = 0.
  - up_full is registered and equals (count == DEPTH).
  - A push while full is discarded and sets up_overflow.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM, one outstanding request at a time:
  - IDLE: when the queue is non-empty, pop the head into holding registers.
    - Legal cmd: go to ISSUE.
    - Illegal cmd: go to RESP with err = 1, without touching the controller.
  - ISSUE: waits until ddr_ready = 1 and ddr_busy = 0. Then drive user_cmd, user_addr and user_data_in from the holding registers, assert user_cmd_vld for exactly one cycle, clear the timeout counter, and go to WAIT. user_cmd, user_addr and user_data_in hold their values until the next ISSUE.
  - WAIT, write: ddr_ack = 1 moves to CONFIRM.
  - WAIT, read: user_data_out_vld = 1 captures user_data_out and moves to CONFIRM.
  - WAIT, either: if the counter reaches TIMEOUT-1 first, go to RESP with err = 1 and no confirm.
  - WAIT: ack or data-valid on the same edge as the timeout wins (CONFIRM).
  - WAIT: ddr_ready dropping does not abort the request.
  - WAIT: ddr_ack seen during a read, or user_data_out_vld seen during a write, is ignored.
  - CONFIRM: ddr_user_confirm = 1 for one cycle, then go to RESP.
  - RESP: up_rsp_vld = 1 for one cycle with up_rsp_data and up_rsp_err, then go to IDLE.
- Latency:
  - A push at edge N into an empty queue with the controller ready gives user_cmd_vld high in cycle N+2.
  - Response comes 2 cycles after the ack or data-valid edge.
- Ordering: responses are returned strictly in push order.

Optional Feature:
- Macro DDR_CMD_QUEUE_STATS_EN.
- When defined, add output stat_o [31:0]:
  - [11:0] completed writes
  - [23:12] completed reads
  - [31:24] errors
  - Each field is a saturating counter, cleared by reset.
- When undefined, no port and no counter logic.

Test Plan:
- Write 0x00001EAF to addr 0x000010, controller acks 3 cycles after user_cmd_vld. Expect:
  - user_cmd = 1 and user_data_in = 0x00001EAF.
  - One ddr_user_confirm.
  - up_rsp_vld with err = 0 and up_rsp_data = 0.
- Read addr 0x000020, controller returns 0xDEADBEEF. Expect up_rsp_data = 0xDEADBEEF and err = 0.
- Push 5 requests back-to-back with ddr_ready = 0. Expect:
  - up_full high after the 4th push; 5th push discarded; up_overflow = 1.
  - After ddr_ready rises, 4 responses in push order.
- Read with the controller never answering. Expect:
  - up_rsp_vld exactly TIMEOUT+1 cycles after user_cmd_vld, with err = 1.
  - ddr_user_confirm never asserted.
- Push cmd = 4'h7. Expect an error response 2 cycles later and user_cmd_vld never asserted.
- Assert rst = 0 during WAIT. Expect all outputs 0 immediately (asynchronous), queue empty, and no response after release.
